dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU load/store port and a DMA/loader port.
// CPU wins by default; a starved DMA request is forced through and then gets a short burst.
module dmem_arbiter #(
   parameter int MAX_WAIT  = 4,
   parameter int DMA_BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        mem_we,
   output logic        mem_re,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int WW = $clog2(MAX_WAIT + 2);
   localparam int BW = $clog2(DMA_BURST + 2);

   typedef enum logic [1:0] {S_IDLE, S_CPU_PRI, S_DMA_BURST} state_t;

   state_t        r_state;
   logic [WW-1:0] r_wait_cnt;
   logic [BW-1:0] r_burst_cnt;
   logic          r_tag_vld;
   logic          r_tag_dma;
   logic [31:0]   r_cpu_rdata;
   logic [31:0]   r_dma_rdata;
   logic [31:0]   r_last_addr;
   logic [31:0]   r_last_wdata;

   logic          w_cpu_req;
   logic          w_dma_req;
   logic          w_forced;
   logic          w_cpu_gnt;
   logic          w_dma_gnt;
   logic          w_any_gnt;
   logic          w_gnt_we;
   logic [31:0]   w_gnt_addr;
   logic [31:0]   w_gnt_wdata;
   logic          w_burst_last;
   logic          w_cpu_rvalid;
   logic          w_dma_rvalid;

   // Requests are masked while reset is held so no grant can leak out combinationally.
   assign w_cpu_req = cpu_req & reset;
   assign w_dma_req = dma_req & reset;
   assign w_forced  = (r_wait_cnt == WW'(MAX_WAIT));

   always_comb begin
      w_dma_gnt = 1'b0;
      w_cpu_gnt = 1'b0;
      if (r_state == S_DMA_BURST) begin
         w_dma_gnt = w_dma_req;
      end else begin
         w_dma_gnt = w_dma_req & (~w_cpu_req | w_forced);
         w_cpu_gnt = w_cpu_req & ~w_dma_gnt;
      end
   end

   // The forced grant that opens a burst is its first beat, so the last in-burst beat is DMA_BURST-1.
   assign w_burst_last = (int'(r_burst_cnt) + 1 >= DMA_BURST - 1);

   assign w_any_gnt   = w_cpu_gnt | w_dma_gnt;
   assign w_gnt_we    = w_dma_gnt ? dma_we    : cpu_we;
   assign w_gnt_addr  = w_dma_gnt ? dma_addr  : cpu_addr;
   assign w_gnt_wdata = w_dma_gnt ? dma_wdata : cpu_wdata;

   assign cpu_gnt   = w_cpu_gnt;
   assign dma_gnt   = w_dma_gnt;
   assign cpu_stall = cpu_req & ~w_cpu_gnt;
   assign mem_we    = w_any_gnt &  w_gnt_we;
   assign mem_re    = w_any_gnt & ~w_gnt_we;
   assign mem_addr  = w_any_gnt ? w_gnt_addr  : r_last_addr;
   assign mem_wdata = w_any_gnt ? w_gnt_wdata : r_last_wdata;

   assign w_cpu_rvalid = r_tag_vld & ~r_tag_dma;
   assign w_dma_rvalid = r_tag_vld &  r_tag_dma;
   assign cpu_rvalid   = w_cpu_rvalid;
   assign dma_rvalid   = w_dma_rvalid;
   assign cpu_rdata    = w_cpu_rvalid ? mem_rdata : r_cpu_rdata;
   assign dma_rdata    = w_dma_rvalid ? mem_rdata : r_dma_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= '0;
         r_burst_cnt <= '0;
      end else begin
         if (w_dma_req & ~w_dma_gnt) begin
            if (!w_forced) r_wait_cnt <= r_wait_cnt + 1'b1;
         end else begin
            r_wait_cnt <= '0;
         end
         case (r_state)
            S_IDLE, S_CPU_PRI: begin
               if (w_dma_gnt & w_cpu_req) begin
                  r_state     <= S_DMA_BURST;
                  r_burst_cnt <= '0;
               end else if (r_state == S_IDLE && w_cpu_gnt) begin
                  r_state <= S_CPU_PRI;
               end else if (r_state == S_CPU_PRI && !w_cpu_req && !w_dma_req) begin
                  r_state <= S_IDLE;
               end
            end
            S_DMA_BURST: begin
               if (!w_dma_req) begin
                  r_state <= S_CPU_PRI;
               end else begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
                  if (w_burst_last) r_state <= S_CPU_PRI;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read tag and per-port data hold; mem_rdata arrives the cycle after mem_re.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tag_vld    <= 1'b0;
         r_tag_dma    <= 1'b0;
         r_cpu_rdata  <= '0;
         r_dma_rdata  <= '0;
         r_last_addr  <= '0;
         r_last_wdata <= '0;
      end else begin
         r_tag_vld <= mem_re;
         r_tag_dma <= w_dma_gnt;
         if (w_cpu_rvalid) r_cpu_rdata <= mem_rdata;
         if (w_dma_rvalid) r_dma_rdata <= mem_rdata;
         if (w_any_gnt) begin
            r_last_addr  <= w_gnt_addr;
            r_last_wdata <= w_gnt_wdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// cycle model built from priority/starvation/burst rules.
module tb_dmem_arbiter;

   localparam int MAX_WAIT  = 4;
   localparam int DMA_BURST = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic [31:0] mem_rdata = '0;
   logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, mem_re;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

   int n_pass = 0;
   int n_total = 0;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .DMA_BURST(DMA_BURST)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: CPU priority, starvation counter, remaining burst beats, pending read owner.
   bit          m_in_burst;
   int          m_left, m_waits, m_pend;
   logic [31:0] m_hold_c, m_hold_d, m_last_addr, m_last_wd;
   bit          e_cg, e_dg, e_stall, e_mwe, e_mre, e_crv, e_drv;
   logic [31:0] e_maddr, e_mwd, e_crd, e_drd;

   task automatic model_reset();
      m_in_burst = 0; m_left = 0; m_waits = 0; m_pend = 0;
      m_hold_c = '0; m_hold_d = '0; m_last_addr = '0; m_last_wd = '0;
   endtask

   task automatic model_eval();
      if (m_in_burst) begin
         e_dg = dma_req;
         e_cg = 0;
      end else begin
         e_dg = dma_req && (!cpu_req || m_waits == MAX_WAIT);
         e_cg = cpu_req && !e_dg;
      end
      e_stall = cpu_req && !e_cg;
      e_mwe   = (e_cg && cpu_we) || (e_dg && dma_we);
      e_mre   = (e_cg && !cpu_we) || (e_dg && !dma_we);
      e_maddr = e_dg ? dma_addr : (e_cg ? cpu_addr : m_last_addr);
      e_mwd   = e_dg ? dma_wdata : (e_cg ? cpu_wdata : m_last_wd);
      e_crv   = (m_pend == 1);
      e_drv   = (m_pend == 2);
      e_crd   = e_crv ? mem_rdata : m_hold_c;
      e_drd   = e_drv ? mem_rdata : m_hold_d;
   endtask

   task automatic model_commit();
      if (dma_req && !e_dg) m_waits = (m_waits + 1 > MAX_WAIT) ? MAX_WAIT : m_waits + 1;
      else m_waits = 0;
      if (m_in_burst) begin
         if (!dma_req) m_in_burst = 0;
         else begin
            m_left = m_left - 1;
            if (m_left <= 0) m_in_burst = 0;
         end
      end else if (e_dg && cpu_req) begin
         m_in_burst = 1;
         m_left = DMA_BURST - 1;
      end
      if (e_crv) m_hold_c = mem_rdata;
      if (e_drv) m_hold_d = mem_rdata;
      if (e_cg || e_dg) begin
         m_last_addr = e_maddr;
         m_last_wd = e_mwd;
      end
      m_pend = (e_dg && !dma_we) ? 2 : ((e_cg && !cpu_we) ? 1 : 0);
   endtask

   function automatic logic [134:0] obs();
      return {cpu_gnt, dma_gnt, cpu_stall, mem_we, mem_re, cpu_rvalid, dma_rvalid,
              mem_addr, mem_wdata, cpu_rdata, dma_rdata};
   endfunction

   function automatic logic [134:0] expv();
      return {e_cg, e_dg, e_stall, e_mwe, e_mre, e_crv, e_drv, e_maddr, e_mwd, e_crd, e_drd};
   endfunction

   task automatic set_in(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic [31:0] mr);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
      mem_rdata = mr;
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic test_reset();
      #2;
      if (obs() !== '0) $display("FAIL reset_outputs got %h exp 0", obs());
      else n_pass++;
      n_total++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_cpu_read();
      set_in(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, $urandom);
      model_eval();
      @(negedge clk);
      if (cpu_gnt !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 32'h10)
         $display("FAIL cpu_read_c0 gnt=%b re=%b addr=%h exp 1 1 00000010", cpu_gnt, mem_re, mem_addr);
      else n_pass++;
      n_total++;
      tick();
      set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF);
      model_eval();
      @(negedge clk);
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dma_rvalid !== 1'b0)
         $display("FAIL cpu_read_c1 rv=%b rd=%h drv=%b exp 1 deadbeef 0", cpu_rvalid, cpu_rdata, dma_rvalid);
      else n_pass++;
      n_total++;
      if (obs() !== expv()) $display("FAIL cpu_read_model got %h exp %h", obs(), expv());
      else n_pass++;
      n_total++;
      tick();
   endtask

   task automatic test_contention();
      for (int i = 0; i < 12; i++) begin
         set_in(1, 0, 32'h100 + i, 32'h0, 1, 0, 32'h200 + i, 32'h0, $urandom);
         model_eval();
         @(negedge clk);
         if (cpu_gnt !== (i < 4 || i >= 8) || dma_gnt !== (i >= 4 && i < 8) ||
             cpu_stall !== (i >= 4 && i < 8))
            $display("FAIL contention c%0d cg=%b dg=%b stall=%b", i, cpu_gnt, dma_gnt, cpu_stall);
         else n_pass++;
         n_total++;
         if (obs() !== expv()) $display("FAIL contention_model c%0d got %h exp %h", i, obs(), expv());
         else n_pass++;
         n_total++;
         tick();
      end
      set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, $urandom);
      model_eval();
      tick();
   endtask

   task automatic test_early_exit();
      for (int i = 0; i < 8; i++) begin
         set_in(1, 1, 32'h300, 32'hA0 + i, (i != 6 && i != 7), 1, 32'h400, 32'hB0 + i, $urandom);
         model_eval();
         @(negedge clk);
         if ((i == 4 || i == 5) && dma_gnt !== 1'b1)
            $display("FAIL early_exit_dgnt c%0d got %b exp 1", i, dma_gnt);
         else if (i == 6 && (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0))
            $display("FAIL early_exit_drop c%0d cg=%b dg=%b exp 0 0", i, cpu_gnt, dma_gnt);
         else if (i == 7 && cpu_gnt !== 1'b1)
            $display("FAIL early_exit_cpu c%0d got %b exp 1", i, cpu_gnt);
         else if (obs() !== expv())
            $display("FAIL early_exit_model c%0d got %h exp %h", i, obs(), expv());
         else n_pass++;
         n_total++;
         tick();
      end
      set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
      model_eval();
      tick();
   endtask

   task automatic test_alternating();
      logic [31:0] rd[4];
      foreach (rd[k]) rd[k] = $urandom;
      for (int i = 0; i < 4; i++) begin
         set_in(i == 0 || i == 2, 0, 32'h20 + 8 * (i / 2), 32'h0, i == 1, 0, 32'h24, 32'h0, rd[i]);
         model_eval();
         @(negedge clk);
         if (i < 3 && (mem_re !== 1'b1 || mem_addr !== 32'h20 + 4 * i))
            $display("FAIL alt_issue c%0d re=%b addr=%h exp 1 %h", i, mem_re, mem_addr, 32'h20 + 4 * i);
         else if (i > 0 && (cpu_rvalid !== (i != 2) || dma_rvalid !== (i == 2) ||
                  ((i == 2) ? dma_rdata : cpu_rdata) !== rd[i]))
            $display("FAIL alt_return c%0d crv=%b drv=%b crd=%h drd=%h exp data %h",
                     i, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, rd[i]);
         else if (obs() !== expv())
            $display("FAIL alt_model c%0d got %h exp %h", i, obs(), expv());
         else n_pass++;
         n_total++;
         tick();
      end
   endtask

   task automatic test_dma_write();
      set_in(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h55, $urandom);
      model_eval();
      @(negedge clk);
      if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 ||
          mem_addr !== 32'h40 || mem_wdata !== 32'h55)
         $display("FAIL dma_write dg=%b we=%b re=%b addr=%h wd=%h exp 1 1 0 40 55",
                  dma_gnt, mem_we, mem_re, mem_addr, mem_wdata);
      else n_pass++;
      n_total++;
      tick();
      set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, $urandom);
      model_eval();
      @(negedge clk);
      if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || mem_addr !== 32'h40)
         $display("FAIL dma_write_after drv=%b crv=%b addr=%h exp 0 0 40", dma_rvalid, cpu_rvalid, mem_addr);
      else n_pass++;
      n_total++;
      tick();
   endtask

   task automatic test_reset_mid_read();
      set_in(0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0, $urandom);
      model_eval();
      @(negedge clk);
      if (dma_gnt !== 1'b1 || mem_re !== 1'b1)
         $display("FAIL rst_mid_grant dg=%b re=%b exp 1 1", dma_gnt, mem_re);
      else n_pass++;
      n_total++;
      #1 reset = 1'b0;
      #1;
      if (obs() !== '0) $display("FAIL rst_mid_outputs got %h exp 0", obs());
      else n_pass++;
      n_total++;
      @(posedge clk);
      #1;
      if (obs() !== '0) $display("FAIL rst_mid_return got %h exp 0", obs());
      else n_pass++;
      n_total++;
      set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h12345678);
      reset = 1'b1;
      model_reset();
      model_eval();
      @(negedge clk);
      if (dma_rvalid !== 1'b0 || obs() !== expv())
         $display("FAIL rst_mid_release drv=%b got %h exp %h", dma_rvalid, obs(), expv());
      else n_pass++;
      n_total++;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom, $urandom,
                $urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom, $urandom, $urandom);
         model_eval();
         @(negedge clk);
         if (obs() !== expv()) $display("FAIL random c%0d got %h exp %h", i, obs(), expv());
         else n_pass++;
         n_total++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_contention();
      test_early_exit();
      test_alternating();
      test_dma_write();
      test_reset_mid_read();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
